// File: rtl/dma_master.sv
// DMA initiator: moves len words between a device valid/ready stream and consecutive memory words, one request outstanding.
// Latency: 3 cycles per word best case in either direction; every output is registered. Backpressure: stalls on dma_ready and on device valid/ready.
module dma_master #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic [15:0]      base_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             prio,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [15:0]      dev_wr_data,
    input  logic             dev_wr_valid,
    output logic             dev_wr_ready,
    output logic [15:0]      dev_rd_data,
    output logic             dev_rd_valid,
    input  logic             dev_rd_ready,
    output logic [14:0]      dma_addr,
    output logic [15:0]      dma_din,
    output logic             dma_en,
    output logic [1:0]       dma_we,
    output logic             dma_priority,
    input  logic [15:0]      dma_dout,
    input  logic             dma_ready,
    input  logic             dma_resp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_REQ,
        S_RESP,
        S_OUT,
        S_FIN
    } state_t;

    // Per-transfer context captured on start; abort is remembered once a request is in flight.
    typedef struct packed {
        logic dir;
        logic prio;
        logic abort;
    } ctx_t;

    state_t           state_q, state_d;
    ctx_t             ctx_q, ctx_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [14:0]      addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dma_en_q, dma_en_d;
    logic [1:0]       dma_we_q, dma_we_d;
    logic             wr_rdy_q, wr_rdy_d;
    logic             rd_vld_q, rd_vld_d;
    logic             prio_out_q, prio_out_d;
    logic             last_word;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = base_addr[0];
    assign last_word       = (cnt_q == LEN_W'(1));

    always_comb begin
        state_d = state_q;
        ctx_d   = ctx_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ctx_d.dir   = dir;
                    ctx_d.prio  = prio;
                    ctx_d.abort = 1'b0;
                    cnt_d       = len;
                    addr_d      = base_addr[15:1];
                    err_d       = 1'b0;
                    if (len == '0) begin
                        state_d = S_FIN;
                    end else if (dir) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (dev_wr_valid) begin
                    data_d  = dev_wr_data;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) begin
                    ctx_d.abort = 1'b1;
                end
                if (dma_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (dma_resp) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (ctx_q.abort || abort) begin
                    // The accepted request has completed; its result is dropped.
                    state_d = S_FIN;
                end else if (ctx_q.dir) begin
                    addr_d  = addr_q + 15'd1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = last_word ? S_FIN : S_FETCH;
                end else begin
                    data_d  = dma_dout;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (abort) begin
                    state_d = S_FIN;
                end else if (dev_rd_ready) begin
                    addr_d  = addr_q + 15'd1;
                    cnt_d   = cnt_q - LEN_W'(1);
                    state_d = last_word ? S_FIN : S_REQ;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave the block as flops.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        dma_en_d   = (state_d == S_REQ);
        dma_we_d   = (state_d == S_REQ && ctx_d.dir) ? 2'b11 : 2'b00;
        wr_rdy_d   = (state_d == S_FETCH);
        rd_vld_d   = (state_d == S_OUT);
        prio_out_d = (state_d != S_IDLE) && ctx_d.prio;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ctx_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dma_en_q   <= 1'b0;
            dma_we_q   <= 2'b00;
            wr_rdy_q   <= 1'b0;
            rd_vld_q   <= 1'b0;
            prio_out_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctx_q      <= ctx_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dma_en_q   <= dma_en_d;
            dma_we_q   <= dma_we_d;
            wr_rdy_q   <= wr_rdy_d;
            rd_vld_q   <= rd_vld_d;
            prio_out_q <= prio_out_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign dev_wr_ready = wr_rdy_q;
    assign dev_rd_valid = rd_vld_q;
    assign dev_rd_data  = data_q;
    assign dma_addr     = addr_q;
    assign dma_din      = data_q;
    assign dma_en       = dma_en_q;
    assign dma_we       = dma_we_q;
    assign dma_priority = prio_out_q;

endmodule

// File: tb/tb_dma_master.sv
// Directed bench for dma_master: a small memory model answers accepted requests, a monitor logs handshakes.
module tb_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        dir = 1'b0;
    logic [15:0] base_addr = 16'h0;
    logic [15:0] len = 16'h0;
    logic        prio = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, err;
    logic [15:0] dev_wr_data = 16'h0;
    logic        dev_wr_valid = 1'b0;
    logic        dev_wr_ready;
    logic [15:0] dev_rd_data;
    logic        dev_rd_valid;
    logic        dev_rd_ready = 1'b0;
    logic [14:0] dma_addr;
    logic [15:0] dma_din;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic        dma_priority;
    logic [15:0] dma_dout = 16'h0;
    logic        dma_ready = 1'b0;
    logic        dma_resp = 1'b0;

    logic        resp_inject = 1'b0;
    logic [15:0] mem [0:32767];

    int vectors = 0;
    int miscompares = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    int rdv_cnt = 0;
    int rd_cnt = 0;
    logic [14:0] acc_addr [0:255];
    logic [15:0] rd_word  [0:255];

    dma_master #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .base_addr(base_addr),
        .len(len), .prio(prio), .abort(abort), .busy(busy), .done(done), .err(err),
        .dev_wr_data(dev_wr_data), .dev_wr_valid(dev_wr_valid), .dev_wr_ready(dev_wr_ready),
        .dev_rd_data(dev_rd_data), .dev_rd_valid(dev_rd_valid), .dev_rd_ready(dev_rd_ready),
        .dma_addr(dma_addr), .dma_din(dma_din), .dma_en(dma_en), .dma_we(dma_we),
        .dma_priority(dma_priority), .dma_dout(dma_dout), .dma_ready(dma_ready), .dma_resp(dma_resp)
    );

    always #5 clk = ~clk;

    // Memory model and monitor: look at the cycle just before the edge that decides it.
    always @(negedge clk) begin
        if (dma_en && dma_ready) begin
            dma_dout = mem[dma_addr];
            dma_resp = resp_inject;
            acc_addr[acc_cnt] = dma_addr;
            acc_cnt++;
        end
        if (done) done_cnt++;
        if (dev_rd_valid) begin
            rdv_cnt++;
            if (dev_rd_ready) begin
                rd_word[rd_cnt] = dev_rd_data;
                rd_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({busy, done, err, dma_en, dma_we, dma_priority, dev_wr_ready, dev_rd_valid,
             dma_addr, dma_din, dev_rd_data} !== 56'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b en=%b we=%b addr=%h required all zero",
                     busy, done, err, dma_en, dma_we, dma_addr);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read2();
        int a0, r0, d0, cyc;
        a0 = acc_cnt; r0 = rd_cnt; d0 = done_cnt;
        mem[15'h0100] = 16'hA5A5;
        mem[15'h0101] = 16'h5A5A;
        dma_ready = 1'b1; dev_rd_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = 16'h0200; len = 16'd2; prio = 1'b1;
        tick();
        start = 1'b0; cyc = 1;
        vectors++;
        if ({busy, dma_en, dma_we, dma_priority, dma_addr} !== {1'b1, 1'b1, 2'b00, 1'b1, 15'h0100}) begin
            miscompares++;
            $display("FAIL read2_req: got busy=%b en=%b we=%b pri=%b addr=%h required 1 1 00 1 0100",
                     busy, dma_en, dma_we, dma_priority, dma_addr);
        end
        tick(); tick(); cyc = 3;
        vectors++;
        if ({dev_rd_valid, dev_rd_data} !== {1'b1, 16'hA5A5}) begin
            miscompares++;
            $display("FAIL read2_first_out: got valid=%b data=%h required 1 a5a5", dev_rd_valid, dev_rd_data);
        end
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        vectors++;
        if (cyc != 7) begin
            miscompares++;
            $display("FAIL read2_done_cycle: got %0d required 7", cyc);
        end
        vectors++;
        if ({acc_addr[a0], acc_addr[a0+1]} !== {15'h0100, 15'h0101} || acc_cnt - a0 != 2) begin
            miscompares++;
            $display("FAIL read2_addrs: got %h %h (n=%0d) required 0100 0101 (n=2)",
                     acc_addr[a0], acc_addr[a0+1], acc_cnt - a0);
        end
        vectors++;
        if ({rd_word[r0], rd_word[r0+1]} !== {16'hA5A5, 16'h5A5A} || rd_cnt - r0 != 2) begin
            miscompares++;
            $display("FAIL read2_words: got %h %h (n=%0d) required a5a5 5a5a (n=2)",
                     rd_word[r0], rd_word[r0+1], rd_cnt - r0);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL read2_end: got busy=%b err=%b dones=%0d required 0 0 1", busy, err, done_cnt - d0);
        end
        prio = 1'b0;
    endtask

    task automatic test_write3();
        logic [15:0] words [0:2];
        int a0;
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        a0 = acc_cnt;
        dma_ready = 1'b0;
        start = 1'b1; dir = 1'b1; base_addr = 16'h0400; len = 16'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dev_wr_ready !== 1'b1 || dma_en !== 1'b0) begin
                miscompares++;
                $display("FAIL write3_fetch%0d: got wr_ready=%b en=%b required 1 0", i, dev_wr_ready, dma_en);
            end
            dev_wr_valid = 1'b1; dev_wr_data = words[i];
            tick();
            dev_wr_valid = 1'b0; dev_wr_data = 16'hDEAD;
            for (int w = 0; w < 3; w++) begin
                vectors++;
                if ({dma_en, dma_we, dma_din, dma_addr, dev_wr_ready} !==
                    {1'b1, 2'b11, words[i], 15'h0200 + 15'(i), 1'b0}) begin
                    miscompares++;
                    $display("FAIL write3_req%0d_wait%0d: got en=%b we=%b din=%h addr=%h required 1 11 %h %h",
                             i, w, dma_en, dma_we, dma_din, dma_addr, words[i], 15'h0200 + 15'(i));
                end
                if (w == 2) dma_ready = 1'b1;
                tick();
            end
            dma_ready = 1'b0;
            vectors++;
            if (dma_en !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL write3_resp%0d: got en=%b done=%b required 0 0", i, dma_en, done);
            end
            tick();
        end
        vectors++;
        if (done !== 1'b1 || err !== 1'b0 || acc_cnt - a0 != 3) begin
            miscompares++;
            $display("FAIL write3_done: got done=%b err=%b accepts=%0d required 1 0 3", done, err, acc_cnt - a0);
        end
        tick();
    endtask

    task automatic test_wrap();
        int a0, r0, cyc;
        a0 = acc_cnt; r0 = rd_cnt;
        mem[15'h7FFF] = 16'hBEEF;
        mem[15'h0000] = 16'h1234;
        dma_ready = 1'b1; dev_rd_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = 16'hFFFE; len = 16'd2;
        tick();
        start = 1'b0; cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        vectors++;
        if ({acc_addr[a0], acc_addr[a0+1]} !== {15'h7FFF, 15'h0000} || cyc != 7) begin
            miscompares++;
            $display("FAIL wrap_addrs: got %h %h done_cycle=%0d required 7fff 0000 7",
                     acc_addr[a0], acc_addr[a0+1], cyc);
        end
        vectors++;
        if ({rd_word[r0], rd_word[r0+1], err} !== {16'hBEEF, 16'h1234, 1'b0}) begin
            miscompares++;
            $display("FAIL wrap_words: got %h %h err=%b required beef 1234 0", rd_word[r0], rd_word[r0+1], err);
        end
        tick();
    endtask

    task automatic test_error();
        int a0, v0, cyc;
        a0 = acc_cnt; v0 = rdv_cnt;
        resp_inject = 1'b1;
        dma_ready = 1'b1; dev_rd_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = 16'h0300; len = 16'd4;
        tick();
        start = 1'b0; cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        resp_inject = 1'b0;
        vectors++;
        if (cyc != 3 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL error_done: got cycle=%0d err=%b required 3 1", cyc, err);
        end
        vectors++;
        if (acc_cnt - a0 != 1 || rdv_cnt - v0 != 0) begin
            miscompares++;
            $display("FAIL error_traffic: got accepts=%0d rd_valid_cycles=%0d required 1 0", acc_cnt - a0, rdv_cnt - v0);
        end
        tick(); tick();
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL error_sticky: got err=%b busy=%b required 1 0", err, busy);
        end
    endtask

    task automatic test_abort_req();
        int a0, v0;
        a0 = acc_cnt; v0 = rdv_cnt;
        dma_ready = 1'b0; dev_rd_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = 16'h0500; len = 16'd3;
        tick();
        vectors++;
        if (err !== 1'b0 || dma_en !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_req_start: got err=%b en=%b required 0 1", err, dma_en);
        end
        base_addr = 16'h0E00; len = 16'd9;
        tick();
        start = 1'b0;
        vectors++;
        if (dma_addr !== 15'h0280) begin
            miscompares++;
            $display("FAIL start_while_busy: got addr=%h required 0280", dma_addr);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if (dma_en !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_req_hold: got en=%b done=%b required 1 0", dma_en, done);
        end
        dma_ready = 1'b1;
        tick();
        dma_ready = 1'b0;
        vectors++;
        if (dma_en !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_req_resp: got en=%b done=%b busy=%b required 0 0 1", dma_en, done, busy);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b1 || dev_rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_req_fin: got done=%b busy=%b rd_valid=%b required 1 1 0", done, busy, dev_rd_valid);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || err !== 1'b0 || acc_cnt - a0 != 1 || rdv_cnt - v0 != 0) begin
            miscompares++;
            $display("FAIL abort_req_end: got busy=%b err=%b accepts=%0d rd_valid=%0d required 0 0 1 0",
                     busy, err, acc_cnt - a0, rdv_cnt - v0);
        end
    endtask

    task automatic test_start_abort();
        int r0, cyc;
        r0 = rd_cnt;
        mem[15'h0400] = 16'hC3C3;
        dma_ready = 1'b1; dev_rd_ready = 1'b1;
        start = 1'b1; abort = 1'b1; dir = 1'b0; base_addr = 16'h0800; len = 16'd1;
        tick();
        start = 1'b0; abort = 1'b0; cyc = 1;
        vectors++;
        if (busy !== 1'b1 || dma_en !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL start_abort_wins: got busy=%b en=%b done=%b required 1 1 0", busy, dma_en, done);
        end
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        vectors++;
        if (cyc != 4 || rd_word[r0] !== 16'hC3C3 || rd_cnt - r0 != 1) begin
            miscompares++;
            $display("FAIL start_abort_xfer: got cycle=%0d word=%h n=%0d required 4 c3c3 1", cyc, rd_word[r0], rd_cnt - r0);
        end
        tick();
    endtask

    task automatic test_len0();
        int a0, d0;
        a0 = acc_cnt; d0 = done_cnt;
        dma_ready = 1'b1;
        start = 1'b1; dir = 1'b0; base_addr = 16'h0100; len = 16'd0;
        tick();
        start = 1'b0;
        vectors++;
        if ({done, busy, dma_en} !== 3'b110) begin
            miscompares++;
            $display("FAIL len0_cycle1: got done=%b busy=%b en=%b required 1 1 0", done, busy, dma_en);
        end
        tick();
        vectors++;
        if ({done, busy, dma_en} !== 3'b000 || acc_cnt - a0 != 0 || done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL len0_end: got done=%b busy=%b accepts=%0d dones=%0d required 0 0 0 1",
                     done, busy, acc_cnt - a0, done_cnt - d0);
        end
        dma_ready = 1'b0;
    endtask

    task automatic test_abort_fetch();
        int a0;
        a0 = acc_cnt;
        start = 1'b1; dir = 1'b1; base_addr = 16'h0A00; len = 16'd2;
        tick();
        start = 1'b0;
        vectors++;
        if (dev_wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_fetch_ready: got %b required 1", dev_wr_ready);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++;
        if ({done, dev_wr_ready, dma_en, err} !== 4'b1000 || acc_cnt - a0 != 0) begin
            miscompares++;
            $display("FAIL abort_fetch_fin: got done=%b wr_ready=%b en=%b err=%b accepts=%0d required 1 0 0 0 0",
                     done, dev_wr_ready, dma_en, err, acc_cnt - a0);
        end
        tick();
    endtask

    task automatic test_rst_mid();
        dma_ready = 1'b0;
        mem[15'h0300] = 16'h7777;
        start = 1'b1; dir = 1'b0; base_addr = 16'h0600; len = 16'd2; prio = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vectors++;
        if (dma_en !== 1'b1 || dma_priority !== 1'b1 || dma_addr !== 15'h0300) begin
            miscompares++;
            $display("FAIL rst_mid_req: got en=%b pri=%b addr=%h required 1 1 0300", dma_en, dma_priority, dma_addr);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if ({busy, done, err, dma_en, dma_we, dma_priority, dev_wr_ready, dev_rd_valid,
             dma_addr, dma_din, dev_rd_data} !== 56'h0) begin
            miscompares++;
            $display("FAIL rst_mid_outputs: got busy=%b en=%b pri=%b addr=%h din=%h required all zero",
                     busy, dma_en, dma_priority, dma_addr, dma_din);
        end
        rst = 1'b0; prio = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || dma_en !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_idle: got busy=%b en=%b required 0 0", busy, dma_en);
        end
    endtask

    initial begin
        test_reset();
        test_read2();
        test_write3();
        test_wrap();
        test_error();
        test_abort_req();
        test_start_abort();
        test_len0();
        test_abort_fetch();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_master.md
# dma_master

DMA initiator for the openMSP430 DMA port: the requesting end of the protocol whose device-side buffering is done by the peripheral word registers. On a `start` pulse it moves `len` 16-bit words between consecutive memory words and a device-side stream, in either direction: device→memory as DMA writes, memory→device as DMA reads. It sits between the DMA controller's device logic and the CPU's `dma_*` pins, with one outstanding DMA request at a time.

## Interface
- `LEN_W`, 16: width of the transfer-length field and word counter.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle request; ignored unless idle.
- `dir`  in  1  1 = device→memory (DMA write), 0 = memory→device (DMA read); latched on `start`.
- `base_addr`  in  16  byte address of first word; bit 0 ignored; latched on `start`.
- `len`  in  LEN_W  number of words; latched on `start`.
- `prio`  in  1  latched on `start`, driven on `dma_priority` for the whole transfer.
- `abort`  in  1  level; terminates an active transfer.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at end of transfer (normal, error or abort).
- `err`  out  1  sticky; set on `dma_resp`=1; cleared on accepted `start`.
- `dev_wr_data`  in  16  word from device (write direction).
- `dev_wr_valid`  in  1 / `dev_wr_ready`  out  1  valid/ready handshake; word taken when both are high.
- `dev_rd_data`  out  16  word to device (read direction).
- `dev_rd_valid`  out  1 / `dev_rd_ready`  in  1  valid/ready handshake; word consumed when both are high.
- `dma_addr`  out  15  word address.
- `dma_din`  out  16  write data.
- `dma_en`  out  1  request.
- `dma_we`  out  2  byte enables; 2'b11 on write, 2'b00 on read.
- `dma_priority`  out  1  request priority.
- `dma_dout`  in  16  read data; valid in the cycle after acceptance.
- `dma_ready`  in  1  request accepted at this edge.
- `dma_resp`  in  1  error response; valid in the cycle after acceptance.

## Operation
- **States:** IDLE, FETCH, REQ, RESP, OUT, FIN.
- **IDLE**
  - `start` with `len`≠0: latch the inputs, set the counter to `len`, set the address to `base_addr[15:1]`, clear `err`.
  - Next state is FETCH when `dir`=1, REQ when `dir`=0.
  - `start` with `len`=0: go to FIN; no `dma_en` is issued.
- **FETCH**
  - `dev_wr_ready`=1.
  - On `dev_wr_valid`: capture `dev_wr_data` into the data register and go to REQ.
- **REQ**
  - `dma_en`=1; `dma_addr`, `dma_we` and `dma_din` are held stable.
  - Stay until `dma_ready`=1 at an edge, then go to RESP.
  - `dma_en` is never dropped before acceptance.
- **RESP** (one cycle)
  - Sample `dma_resp`. If it is 1: set `err`, go to FIN.
  - Read direction: capture `dma_dout` into the data register and go to OUT.
  - Write direction: increment the address and decrement the counter. Go to FIN if the counter reaches 0, otherwise FETCH.
- **OUT**
  - `dev_rd_valid`=1; `dev_rd_data` = data register.
  - On `dev_rd_ready`: increment the address, decrement the counter, then go to FIN if the counter is 0, otherwise REQ.
- **FIN**: `done`=1 for one cycle, then IDLE.
- **Address wrap:** 15-bit word address wraps 0x7FFF→0x0000; no error is raised.
- **Abort**
  - In FETCH or OUT: go to FIN at the next edge. The pending device word is not consumed or produced; `err` is unchanged.
  - In REQ or RESP: abort is latched and the accepted request completes through RESP. FIN follows; the RESP data is discarded and the counter is not decremented.
- **Simultaneous events**
  - `start` together with `abort` in IDLE: `start` wins, and the abort is ignored.
  - `start` while busy is ignored.
- **Reset** (from any state, mid-request included)
  - State → IDLE.
  - Zero on the next edge: all outputs, the counter, the address, the data register and `err`.

## Timing
- All outputs are registered or decoded from state/registers only; there are no combinational paths from `dma_ready`, `dev_*_valid` or `ready`.
- Reset value of every output: 0.
- `busy` rises the cycle after `start` and falls in the cycle after FIN. It is high in FIN.
- Best case, read direction:
  - start@0, REQ@1 with `dma_ready`=1, RESP@2, `dev_rd_valid`@3.
  - Per-word throughput: 3 cycles.
- Best case, write direction: FETCH→REQ→RESP, 3 cycles per word.
- `len`=0: `done` at cycle 1.

## Test plan
- **Read, 2 words:** `base_addr`=0x0200, `len`=2, `dma_ready` always 1, memory returns 0xA5A5 then 0x5A5A → `dma_addr` 0x0100 then 0x0101; `dev_rd_data` 0xA5A5 then 0x5A5A; `done` once; `err`=0.
- **Write, 3 words with backpressure:**
  - Setup: `dma_ready` low for 2 cycles on each request; device words 0x1111, 0x2222, 0x3333.
  - Required: `dma_en`/`dma_din` held stable while waiting; `dma_we`=2'b11; addresses increment; `done` after the third RESP.
- **Wrap:** `base_addr`=0xFFFE, `len`=2, read → `dma_addr` 0x7FFF then 0x0000.
- **Error:** `dma_resp`=1 on the first word of a `len`=4 read → `err`=1, `done` pulse, no `dev_rd_valid`, only one `dma_en` acceptance.
- **Abort in REQ:** abort while REQ waits with `dma_ready`=0; later `dma_ready`=1 → request completes, then FIN, `done`=1, `busy`=0, no `dev_rd_valid`.
- **Corner cases:**
  - `len`=0: `done` at cycle 1 with `dma_en` never high.
  - `rst` asserted mid-REQ: all outputs 0 after the next edge.
